// File: rtl/fmul_pack_stage_pkg.sv
// Shared binary32 constants, result record and pack function for the multiplier pack stage.
// Replaces the old fpu754_defs.vh include.
package fmul_pack_stage_pkg;

    localparam int unsigned FP32_BIAS     = 127;
    localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
    localparam int unsigned FP32_EXP_W    = 8;
    localparam int unsigned FP32_FRAC_W   = 23;
    localparam int unsigned FP32_W        = 32;
    localparam int unsigned FLAGS_W       = 3;

    localparam int unsigned FLAG_OVF  = 2;
    localparam int unsigned FLAG_UNF  = 1;
    localparam int unsigned FLAG_ZERO = 0;

    typedef struct packed {
        logic [FLAGS_W-1:0] flags;
        logic [FP32_W-1:0]  data;
    } fmul_result_t;

    localparam int unsigned RESULT_W = $bits(fmul_result_t);

    // Priority zero > underflow > overflow; no denormals are produced.
    function automatic fmul_result_t pack_result(input logic [31:0] x3,
                                                 input logic [8:0]  base_ei,
                                                 input int unsigned bias);
        fmul_result_t    res;
        logic signed [9:0] e;
        e = 10'({1'b0, base_ei}) - 10'(bias);
        res = '0;
        res.data[31] = x3[31];
        if (!x3[23]) begin
            res.flags[FLAG_ZERO] = 1'b1;
        end else if (e <= 10'sd0) begin
            res.flags[FLAG_UNF] = 1'b1;
        end else if (e >= 10'sd255) begin
            res.flags[FLAG_OVF] = 1'b1;
            res.data[30:23]     = FP32_EXP_MAX;
        end else begin
            res.data[30:23] = e[7:0];
            res.data[22:0]  = x3[22:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fmul_pack_stage_if.sv
// Stage-3 input stream and result output stream of the pack stage.
interface fmul_pack_stage_if;

    logic [31:0] x3;
    logic [8:0]  base_ei;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output x3, base_ei, in_valid, out_ready,
        input  in_ready, out_data, out_flags, out_valid
    );

    modport slave (
        input  x3, base_ei, in_valid, out_ready,
        output in_ready, out_data, out_flags, out_valid
    );

endinterface

// File: rtl/fmul_out_fifo.sv
// Output FIFO for packed results; push while full is taken only alongside a pop.
module fmul_out_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is masked while empty so the output reads zero after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fmul_pack_stage.sv
// Stage 4 of the binary32 multiplier: pack/saturate/flush, P-reg, output FIFO, in_ready, err_ovr.
// Optional FMUL_STICKY_FLAGS_EN adds sticky_flags/flags_clr.
module fmul_pack_stage
    import fmul_pack_stage_pkg::*;
#(
    parameter int unsigned BIAS       = FP32_BIAS,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    fmul_pack_stage_if.slave  bus,
    output logic              err_ovr
`ifdef FMUL_STICKY_FLAGS_EN
    ,
    output logic [2:0]        sticky_flags,
    input  logic              flags_clr
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    fmul_result_t  pack_comb;
    fmul_result_t  p_res;
    logic          p_valid;
    fmul_result_t  head;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          push;
    logic          drop;
    logic [OW-1:0] occupancy;

    assign pack_comb = pack_result(bus.x3, bus.base_ei, BIAS);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_res   <= '0;
        end else begin
            p_valid <= bus.in_valid;
            if (bus.in_valid) begin
                p_res <= pack_comb;
            end
        end
    end

    assign pop  = bus.out_valid && bus.out_ready;
    assign push = p_valid && (!fifo_full || pop);
    assign drop = p_valid && fifo_full && !pop;

    fmul_out_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (p_res),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // One slot is reserved for the result already registered upstream.
    assign occupancy     = OW'(fifo_count) + OW'(p_valid);
    assign bus.in_ready  = (occupancy <= OW'(FIFO_DEPTH - 2));
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head.data;
    assign bus.out_flags = head.flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovr <= 1'b0;
        end else if (drop) begin
            err_ovr <= 1'b1;
        end
    end

`ifdef FMUL_STICKY_FLAGS_EN
    logic [2:0] popped_flags;
    assign popped_flags = pop ? head.flags : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= '0;
        end else if (flags_clr) begin
            sticky_flags <= popped_flags;
        end else begin
            sticky_flags <= sticky_flags | popped_flags;
        end
    end
`endif

endmodule

// File: tb/tb_fmul_pack_stage.sv
// Scoreboard bench for fmul_pack_stage: directed packs, boundaries, backpressure, overrun, reset.
module tb_fmul_pack_stage;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_ovr;
`ifdef FMUL_STICKY_FLAGS_EN
    logic [2:0] sticky_flags;
    logic       flags_clr = 1'b0;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [34:0] sb [$];

    always #5 clk = ~clk;

    fmul_pack_stage_if bus ();

    fmul_pack_stage #(
        .BIAS       (127),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .err_ovr (err_ovr)
`ifdef FMUL_STICKY_FLAGS_EN
        ,
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr)
`endif
    );

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference packing written directly from the binary32 rules, {flags, data}.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [8:0] be);
        int e;
        e = int'(be) - 127;
        if (!x[23])        return {3'b001, x[31], 31'h0};
        else if (e <= 0)   return {3'b010, x[31], 31'h0};
        else if (e >= 255) return {3'b100, x[31], 8'hFF, 23'h0};
        else               return {3'b000, x[31], 8'(e), x[22:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] x, input logic [8:0] be, input bit expect_kept);
        bus.x3       = x;
        bus.base_ei  = be;
        bus.in_valid = 1'b1;
        if (expect_kept) sb.push_back(model(x, be));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        bus.out_ready = 1'b1;
        while ((sb.size() != 0 || bus.out_valid) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check({tag, "_timeout"}, 35'(sb.size()), 35'd0);
    endtask

    // Scoreboard monitor: a pop happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) check("unexpected_out", {bus.out_flags, bus.out_data}, 35'h0);
            else check("out", {bus.out_flags, bus.out_data}, sb.pop_front());
        end
    end

    initial begin
        logic [31:0] rx;
        logic [8:0]  rb;
        int unsigned accepts;
        int unsigned guard;

        bus.x3 = '0; bus.base_ei = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 35'(bus.out_valid), 35'd0);
        check("rst_in_ready",  35'(bus.in_ready),  35'd1);
        check("rst_out",       {bus.out_flags, bus.out_data}, 35'h0);
        check("rst_err_ovr",   35'(err_ovr), 35'd0);
        rst = 1'b0;
        tick();

        // 1.5 * 2.0 with two-cycle latency
        issue(32'h00C00000, 9'd255, 1'b1);
        check("lat1_valid", 35'(bus.out_valid), 35'd0);
        tick();
        check("lat2_valid", 35'(bus.out_valid), 35'd1);
        check("lat2_data",  {bus.out_flags, bus.out_data}, {3'b000, 32'h40400000});
        drain("lat");

        // Directed patterns and exponent boundaries
        issue(32'h80800000, 9'd400, 1'b1);
        issue(32'h00800000, 9'd100, 1'b1);
        issue(32'h00000000, 9'd300, 1'b1);
        issue(32'h80A00001, 9'd127, 1'b1);
        issue(32'h00A00001, 9'd128, 1'b1);
        issue(32'h00FFFFFF, 9'd381, 1'b1);
        issue(32'h80FFFFFF, 9'd382, 1'b1);
        drain("directed");
        check("dir_model_ovf", model(32'h80800000, 9'd400), {3'b100, 32'hFF800000});

        // Random stream, issuing only while in_ready
        for (int i = 0; i < 24; i++) begin
            guard = 0;
            while (!bus.in_ready && guard < 20) begin tick(); guard++; end
            rx = $urandom;
            if ((i % 5) != 0) rx[23] = 1'b1;
            rb = 9'($urandom_range(0, 511));
            issue(rx, rb, 1'b1);
        end
        drain("random");

        // Backpressure: in_ready must drop after DEPTH-1 accepts, nothing lost
        bus.out_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < 10 && bus.in_ready; i++) begin
            issue(32'h00C00000 | 32'(i), 9'(200 + i), 1'b1);
            accepts++;
        end
        check("bp_accepts", 35'(accepts), 35'(DEPTH - 1));
        repeat (3) tick();
        check("bp_in_ready", 35'(bus.in_ready), 35'd0);
        check("bp_head_stable", {bus.out_flags, bus.out_data}, sb[0]);
        check("bp_err_ovr", 35'(err_ovr), 35'd0);
        drain("bp");

        // Overrun: fill, then force in_valid; only the first forced result fits
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10 && bus.in_ready; i++) begin
            issue(32'h00900000 | 32'(i), 9'(150 + i), 1'b1);
        end
        issue(32'h00D00000, 9'd160, 1'b1);
        check("ovr_err_before_drop", 35'(err_ovr), 35'd0);
        for (int i = 0; i < 3; i++) issue(32'h80E00000 | 32'(i), 9'd170, 1'b0);
        repeat (2) tick();
        check("ovr_err_set", 35'(err_ovr), 35'd1);
        check("ovr_head", {bus.out_flags, bus.out_data}, sb[0]);
        drain("ovr");
        check("ovr_err_sticky", 35'(err_ovr), 35'd1);

        // Reset mid-stream with three results queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(32'h00B00000, 9'(130 + i), 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 35'(bus.out_valid), 35'd0);
        check("midrst_in_ready",  35'(bus.in_ready),  35'd1);
        check("midrst_err_ovr",   35'(err_ovr),       35'd0);
`ifdef FMUL_STICKY_FLAGS_EN
        check("midrst_sticky",    35'(sticky_flags),  35'd0);
`endif
        rst = 1'b0;
        tick();
        issue(32'h80800000, 9'd128, 1'b1);
        drain("post_rst");
        check("post_rst_empty", 35'(bus.out_valid), 35'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
